signal_generator: RTL and testbench

Programmable square-wave source and the transmit-side counterpart of `frequency_counter`. It takes a two-digit BCD target N (0–99) and emits exactly N rising edges on `signal` in every window of `update_period` clocks, using the same window length. The windows restart on each new target so that a downstream `frequency_counter` on the same period reads back N. It is used as on-chip stimulus and as a loopback source for display/counter bring-up.

---
 rtl/signal_generator_pkg.sv | 18 +
 rtl/signal_generator_if.sv | 24 ++
 rtl/bcd_to_binary.sv | 43 ++++
 rtl/signal_generator.sv | 115 +++++++++++
 tb/tb_signal_generator.sv | 278 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/signal_generator_pkg.sv
// Shared types, limits and helpers for the signal generator and its BCD converter.
package signal_generator_pkg;

  typedef enum logic [0:0] {
    StRun,
    StConvert
  } state_e;

  localparam int unsigned MAX_DIGIT   = 9;
  localparam int unsigned MAX_COUNT   = 99;
  localparam int unsigned INC_WIDTH   = 8;
  localparam int unsigned VALUE_WIDTH = $clog2(MAX_COUNT + 1);

  function automatic logic [3:0] clamp_digit(input logic [3:0] d);
    return (d > 4'(MAX_DIGIT)) ? 4'(MAX_DIGIT) : d;
  endfunction

endpackage

// File: rtl/signal_generator_if.sv
// Control/status bundle between a stimulus master and the signal generator.
interface signal_generator_if #(
  parameter int unsigned BITS = 12
) ();
  logic [3:0]      ten_count;
  logic [3:0]      unit_count;
  logic            load;
  logic [BITS-1:0] period;
  logic            period_load;
  logic            enable;
  logic            signal;
  logic            window;
  logic            busy;

  modport master (
    output ten_count, unit_count, load, period, period_load, enable,
    input  signal, window, busy
  );

  modport slave (
    input  ten_count, unit_count, load, period, period_load, enable,
    output signal, window, busy
  );
endinterface

// File: rtl/bcd_to_binary.sv
// Sequential two-digit BCD to binary: starts at the units digit, adds ten once per cycle.
module bcd_to_binary
  import signal_generator_pkg::*;
(
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   start_i,
  input  logic [3:0]             ten_i,
  input  logic [3:0]             unit_i,
  output logic                   busy_o,
  output logic                   done_o,
  output logic [VALUE_WIDTH-1:0] value_o
);

  logic                   busy_q;
  logic [3:0]             cnt_q;
  logic [VALUE_WIDTH-1:0] val_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
      val_q  <= '0;
    end else if (start_i) begin
      busy_q <= 1'b1;
      cnt_q  <= clamp_digit(ten_i);
      val_q  <= VALUE_WIDTH'(clamp_digit(unit_i));
    end else if (busy_q) begin
      if (cnt_q != 4'd0) begin
        cnt_q <= cnt_q - 1'b1;
        val_q <= val_q + VALUE_WIDTH'(10);
      end else begin
        busy_q <= 1'b0;
      end
    end
  end

  // Final busy cycle: the value is complete and the caller may act on it this cycle.
  assign done_o  = busy_q & (cnt_q == 4'd0);
  assign busy_o  = busy_q;
  assign value_o = val_q;

endmodule

// File: rtl/signal_generator.sv
// Square-wave source emitting N rising edges per window of P clocks via a phase accumulator.
module signal_generator
  import signal_generator_pkg::*;
#(
  parameter int unsigned UPDATE_PERIOD = 1200,
  parameter int unsigned BITS          = 12
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  signal_generator_if.slave bus
);

  logic                   conv_busy;
  logic                   conv_done;
  logic [VALUE_WIDTH-1:0] conv_value;

  bcd_to_binary u_conv (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .start_i (bus.load),
    .ten_i   (bus.ten_count),
    .unit_i  (bus.unit_count),
    .busy_o  (conv_busy),
    .done_o  (conv_done),
    .value_o (conv_value)
  );

  state_e                 state_q;
  logic [VALUE_WIDTH-1:0] target_q;
  logic [BITS:0]          acc_q;
  logic [BITS-1:0]        wcnt_q;
  logic [BITS-1:0]        period_q;
  logic [BITS-1:0]        staged_q;
  logic                   signal_q;
  logic                   window_q;
  logic                   active_q;

  logic [INC_WIDTH-1:0] inc;
  logic [BITS+1:0]      sum;
  logic [BITS+1:0]      sum_wrap;
  logic                 hit;
  logic                 last;
  logic                 unused_sum_msb;

  // One extra bit on the sum keeps the hit test exact even when inc >= P lets acc grow.
  always_comb begin
    inc            = {target_q, 1'b0};
    sum            = {1'b0, acc_q} + (BITS+2)'(inc);
    sum_wrap       = sum - (BITS+2)'(period_q);
    hit            = sum >= (BITS+2)'(period_q);
    last           = (wcnt_q == period_q - 1'b1);
    unused_sum_msb = sum[BITS+1] ^ sum_wrap[BITS+1];
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= StRun;
      target_q <= '0;
      acc_q    <= '0;
      wcnt_q   <= '0;
      period_q <= BITS'(UPDATE_PERIOD);
      staged_q <= BITS'(UPDATE_PERIOD);
      signal_q <= 1'b0;
      window_q <= 1'b0;
      active_q <= 1'b0;
    end else begin
      if (bus.period_load && (|bus.period[BITS-1:1])) staged_q <= bus.period;

      if (bus.load) begin
        state_q  <= StConvert;
        active_q <= 1'b0;
        wcnt_q   <= '0;
        acc_q    <= '0;
        signal_q <= 1'b0;
        window_q <= 1'b0;
      end else if (state_q == StConvert) begin
        if (conv_done) begin
          state_q  <= StRun;
          target_q <= conv_value;
          period_q <= staged_q;
          active_q <= bus.enable;
          window_q <= bus.enable;
        end
      end else if (!bus.enable) begin
        active_q <= 1'b0;
        wcnt_q   <= '0;
        acc_q    <= '0;
        signal_q <= 1'b0;
        window_q <= 1'b0;
      end else if (!active_q || last) begin
        // Window boundary: restart from a clean low phase with the staged period.
        active_q <= 1'b1;
        wcnt_q   <= '0;
        acc_q    <= '0;
        signal_q <= 1'b0;
        window_q <= 1'b1;
        period_q <= staged_q;
      end else begin
        wcnt_q   <= wcnt_q + 1'b1;
        window_q <= 1'b0;
        if (hit) begin
          acc_q    <= sum_wrap[BITS:0];
          signal_q <= ~signal_q;
        end else begin
          acc_q <= sum[BITS:0];
        end
      end
    end
  end

  assign bus.signal = signal_q;
  assign bus.window = window_q;
  assign bus.busy   = conv_busy;

endmodule

// File: tb/tb_signal_generator.sv
// Self-checking bench: per-cycle comparison against an arithmetic model plus directed literal pins.
module tb_signal_generator;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  signal_generator_if #(.BITS(12)) bus ();

  signal_generator #(
    .UPDATE_PERIOD (1200),
    .BITS          (12)
  ) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  // Model: conversion as a busy-cycle countdown, signal from the edge-count formula.
  bit m_conv;
  int m_left, m_pend, m_n, m_p, m_staged, m_w;
  bit m_started;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic exp_signal();
    int inc;
    if (m_conv || !m_started) return 1'b0;
    inc = 2 * m_n;
    if (inc == 0) return 1'b0;
    if (inc >= m_p) return logic'(m_w % 2);
    return logic'(((m_w * inc) / m_p) % 2);
  endfunction

  function automatic logic exp_window();
    return !m_conv && m_started && (m_w == 0);
  endfunction

  task automatic model_reset();
    m_conv = 1'b0; m_left = 0; m_pend = 0; m_n = 0;
    m_p = 1200; m_staged = 1200; m_started = 1'b0; m_w = 0;
  endtask

  task automatic model_update();
    int t, u, old_staged;
    old_staged = m_staged;
    if (bus.load) begin
      t = (bus.ten_count > 9) ? 9 : int'(bus.ten_count);
      u = (bus.unit_count > 9) ? 9 : int'(bus.unit_count);
      m_conv = 1'b1; m_left = t + 1; m_pend = 10 * t + u; m_started = 1'b0; m_w = 0;
    end else if (m_conv) begin
      m_left--;
      if (m_left == 0) begin
        m_conv = 1'b0; m_n = m_pend; m_p = old_staged; m_started = bus.enable; m_w = 0;
      end
    end else if (!bus.enable) begin
      m_started = 1'b0; m_w = 0;
    end else if (!m_started || m_w == m_p - 1) begin
      m_started = 1'b1; m_w = 0; m_p = old_staged;
    end else begin
      m_w++;
    end
    if (bus.period_load && bus.period >= 2) m_staged = int'(bus.period);
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    @(negedge clk);
    bus.load = 1'b0;
    bus.period_load = 1'b0;
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("signal", bus.signal, exp_signal());
      check("window", bus.window, exp_window());
      check("busy", bus.busy, m_conv);
    end
  end

  task automatic do_load(input int t, input int u);
    bus.ten_count = 4'(t);
    bus.unit_count = 4'(u);
    bus.load = 1'b1;
  endtask

  task automatic stage_period(input int p);
    bus.period = 12'(p);
    bus.period_load = 1'b1;
  endtask

  task automatic count_busy(output int n);
    n = 0;
    while (bus.busy && n < 40) begin
      n++;
      step();
    end
  endtask

  // Measures the window starting at the next (or current) window pulse.
  task automatic measure_window(output int len, output int rises, output int first_high);
    int guard = 0;
    logic prev;
    len = 0; rises = 0; first_high = -1;
    while (!bus.window && guard < 5000) begin
      step();
      guard++;
    end
    if (!bus.window) begin
      checks++; errors++;
      $display("FAIL window_wait actual=timeout required=pulse");
      return;
    end
    prev = bus.signal;
    while (len < 5000) begin
      step();
      len++;
      if (bus.window) break;
      if (bus.signal && !prev) begin
        rises++;
        if (first_high < 0) first_high = len;
      end
      prev = bus.signal;
    end
  endtask

  initial begin
    #3ms;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, len, rises, first, cnt;
    bus.ten_count = '0; bus.unit_count = '0; bus.load = 1'b0;
    bus.period = 12'd1200; bus.period_load = 1'b0; bus.enable = 1'b1;
    model_reset();
    repeat (3) @(negedge clk);
    check("rst_signal", bus.signal, 1'b0);
    check("rst_window", bus.window, 1'b0);
    check("rst_busy", bus.busy, 1'b0);
    rst_n = 1'b1;
    chk_en = 1'b1;

    // N=0 after reset: silent output, window every 1200 cycles
    measure_window(len, rises, first);
    check("n0_len", len, 1200);
    check("n0_rises", rises, 0);

    // Basic rate N=25, P=1200
    do_load(2, 5);
    step();
    count_busy(n);
    check("basic_busy_len", n, 3);
    check("basic_window_after_busy", bus.window, 1'b1);
    measure_window(len, rises, first);
    check("basic_len", len, 1200);
    check("basic_rises", rises, 25);
    check("basic_first_high", first, 24);

    // Period change mid-window takes effect at the next window only
    repeat (300) step();
    stage_period(600);
    step();
    cnt = 301;
    while (!bus.window && cnt < 3000) begin
      step();
      cnt++;
    end
    check("len_before_change", cnt, 1200);
    measure_window(len, rises, first);
    check("len_after_change", len, 600);
    check("rises_after_change", rises, 25);
    stage_period(1);
    measure_window(len, rises, first);
    check("period1_ignored", len, 600);

    // Saturation with simultaneous strobes: 2N=198 >= P=100
    stage_period(100);
    do_load(9, 9);
    step();
    count_busy(n);
    check("sat_busy_len", n, 10);
    measure_window(len, rises, first);
    check("sat_len", len, 100);
    check("sat_rises", rises, 50);
    check("sat_first_high", first, 1);

    // Clamping and restart mid-conversion
    stage_period(1200);
    do_load(12, 3);
    step();
    check("clamp_busy_start", bus.busy, 1'b1);
    repeat (4) step();
    do_load(12, 3);
    step();
    count_busy(n);
    check("restart_busy_len", n, 10);
    measure_window(len, rises, first);
    check("clamp_rises", rises, 93);
    check("clamp_first_high", first, 7);

    // Randomized traffic against the model
    for (int it = 0; it < 30; it++) begin
      case ($urandom_range(0, 3))
        0: do_load(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)));
        1: stage_period(int'($urandom_range(0, 300)));
        2: bus.enable = ~bus.enable;
        default: begin
          do_load(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)));
          stage_period(int'($urandom_range(2, 300)));
        end
      endcase
      repeat ($urandom_range(1, 400)) step();
    end
    bus.enable = 1'b1;

    // Idle: N=0, enable toggling
    stage_period(200);
    do_load(0, 0);
    step();
    count_busy(n);
    check("idle_busy_len", n, 1);
    bus.enable = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      check("idle_window_low", bus.window, 1'b0);
    end
    bus.enable = 1'b1;
    step();
    check("idle_window_after_enable", bus.window, 1'b1);
    measure_window(len, rises, first);
    check("idle_len", len, 200);
    check("idle_rises", rises, 0);

    // Asynchronous reset while signal is high
    stage_period(1200);
    do_load(2, 5);
    step();
    count_busy(n);
    cnt = 0;
    while (!bus.signal && cnt < 200) begin
      step();
      cnt++;
    end
    check("pre_reset_signal_high", bus.signal, 1'b1);
    chk_en = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_signal", bus.signal, 1'b0);
    check("async_rst_window", bus.window, 1'b0);
    check("async_rst_busy", bus.busy, 1'b0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    chk_en = 1'b1;
    measure_window(len, rises, first);
    check("post_reset_len", len, 1200);
    check("post_reset_rises", rises, 0);

    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
